// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and defaults used by the data-memory access controller
package cpu_pkg;

    localparam int DMEM_LATENCY_DEF = 4;
    localparam int DMEM_LAT_CW      = 4;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lat_cnt.sv
// rtl/dmem_lat_cnt.sv - loadable latency down-counter with zero flag
module dmem_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - multi-cycle data-memory access sequencer that stalls the pipeline
module dmem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int LATENCY = DMEM_LATENCY_DEF,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_en,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          stall,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   acc_cnt
);

    localparam logic [DMEM_LAT_CW-1:0] LOAD_VAL = DMEM_LAT_CW'(LATENCY - 1);

    dmem_state_t   state_q, state_d;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [15:0]   acc_q;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;

    dmem_lat_cnt #(
        .W (DMEM_LAT_CW)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        mem_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (req_en) begin
                    stall    = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = DM_BUSY;
                end
            end
            DM_BUSY: begin
                stall  = 1'b1;
                mem_en = 1'b1;
                if (cnt_zero) begin
                    state_d = DM_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            // The instruction in MEM is still the one just served; its req_en is ignored here.
            DM_DONE: begin
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DM_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_load) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if ((state_q == DM_BUSY) && cnt_zero) begin
                acc_q <= acc_q + 16'd1;
                if (!wr_q) begin
                    rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_wr      = mem_en & wr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == DM_DONE) & ~wr_q;
    assign acc_cnt     = acc_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed, table-driven bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;

    logic        r4_en, r4_wr;
    logic [15:0] r4_addr, r4_wdata;
    logic        stall4, valid4, m4_en, m4_wr;
    logic [15:0] rdata4, m4_addr, m4_wdata, m4_rdata, acc4;

    logic        r1_en, r1_wr;
    logic [15:0] r1_addr, r1_wdata;
    logic        stall1, valid1, m1_en, m1_wr;
    logic [15:0] rdata1, m1_addr, m1_wdata, m1_rdata, acc1;

    logic [15:0] mem [0:255];

    int n_cmp;
    int n_bad;

    dmem_access_ctrl #(.LATENCY(4), .AW(16), .DW(16)) dut4 (
        .clk(clk), .rst(rst), .req_en(r4_en), .req_wr(r4_wr), .req_addr(r4_addr),
        .req_wdata(r4_wdata), .stall(stall4), .rdata(rdata4), .rdata_valid(valid4),
        .mem_en(m4_en), .mem_wr(m4_wr), .mem_addr(m4_addr), .mem_wdata(m4_wdata),
        .mem_rdata(m4_rdata), .acc_cnt(acc4)
    );

    dmem_access_ctrl #(.LATENCY(1), .AW(16), .DW(16)) dut1 (
        .clk(clk), .rst(rst), .req_en(r1_en), .req_wr(r1_wr), .req_addr(r1_addr),
        .req_wdata(r1_wdata), .stall(stall1), .rdata(rdata1), .rdata_valid(valid1),
        .mem_en(m1_en), .mem_wr(m1_wr), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .acc_cnt(acc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[16] <= 16'h1234;
        end else if (m4_en && m4_wr) begin
            mem[m4_addr[7:0]] <= m4_wdata;
        end
    end

    assign m4_rdata = mem[m4_addr[7:0]];
    assign m1_rdata = (m1_addr == 16'h0004) ? 16'h00FF : 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic access4(input logic wr, input logic [15:0] a, input logic [15:0] d,
                           output int busy, output logic [15:0] rd, output logic vld);
        int n;
        busy = 0;
        @(posedge clk); #1;
        r4_en = 1'b1; r4_wr = wr; r4_addr = a; r4_wdata = d;
        @(negedge clk);
        chk("req_cycle_stall", {31'd0, stall4}, 32'd1);
        @(posedge clk); #1;
        r4_en = 1'b0; r4_wr = ~wr; r4_addr = 16'hFFFF; r4_wdata = ~d;
        n = 0;
        @(negedge clk);
        while (stall4 && n < 20) begin
            busy++;
            chk("busy_mem_en", {31'd0, m4_en}, 32'd1);
            chk("busy_mem_addr", {16'd0, m4_addr}, {16'd0, a});
            chk("busy_mem_wr", {31'd0, m4_wr}, {31'd0, wr});
            if (wr) chk("busy_mem_wdata", {16'd0, m4_wdata}, {16'd0, d});
            n++;
            @(negedge clk);
        end
        rd  = rdata4;
        vld = valid4;
        chk("done_mem_en", {31'd0, m4_en}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          busy;
        logic [15:0] rd;
        logic        vld;
        logic [15:0] acc_before;
        logic [13:0] st_pat, en_pat, vl_pat;
        logic        bad_flag;

        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b1};
        vecs[1] = '{1'b1, 16'h0020, 16'hBEEF, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b1};
        vecs[3] = '{1'b1, 16'h0030, 16'h5A5A, 16'hBEEF, 1'b0};
        vecs[4] = '{1'b0, 16'h0030, 16'h0000, 16'h5A5A, 1'b1};
        vecs[5] = '{1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b1};
        vecs[6] = '{1'b1, 16'h0010, 16'h0001, 16'h0000, 1'b0};
        vecs[7] = '{1'b0, 16'h0010, 16'h0000, 16'h0001, 1'b1};

        rst = 1'b1;
        r4_en = 1'b0; r4_wr = 1'b0; r4_addr = 16'h0; r4_wdata = 16'h0;
        r1_en = 1'b0; r1_wr = 1'b0; r1_addr = 16'h0; r1_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall4}, 32'd0);
        chk("rst_mem_en", {31'd0, m4_en}, 32'd0);
        chk("rst_valid", {31'd0, valid4}, 32'd0);
        chk("rst_rdata", {16'd0, rdata4}, 32'd0);
        chk("rst_acc", {16'd0, acc4}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            acc_before = acc4;
            access4(vecs[i].wr, vecs[i].addr, vecs[i].wdata, busy, rd, vld);
            chk("vec_busy_cycles", busy, 32'd4);
            chk("vec_rdata", {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
            chk("vec_valid", {31'd0, vld}, {31'd0, vecs[i].exp_valid});
            chk("vec_acc", {16'd0, acc4}, {16'd0, 16'(acc_before + 16'd1)});
            chk("vec_acc_abs", {16'd0, acc4}, i + 1);
            @(negedge clk);
            chk("idle_rdata_hold", {16'd0, rdata4}, {16'd0, vecs[i].exp_rdata});
            chk("idle_valid", {31'd0, valid4}, 32'd0);
        end

        // Back-to-back: read 0x0010 then write 0x0012, req_en held high through DONE.
        acc_before = acc4;
        st_pat = '0; en_pat = '0; vl_pat = '0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c <= 5) begin
                r4_en = 1'b1; r4_wr = 1'b0; r4_addr = 16'h0010; r4_wdata = 16'h0;
            end else if (c <= 11) begin
                r4_en = 1'b1; r4_wr = 1'b1; r4_addr = 16'h0012; r4_wdata = 16'h7777;
            end else begin
                r4_en = 1'b0;
            end
            @(negedge clk);
            st_pat[c] = stall4;
            en_pat[c] = m4_en;
            vl_pat[c] = valid4;
            if (c == 5) chk("b2b_rdata", {16'd0, rdata4}, 32'h0001);
            if (c == 7) chk("b2b_wr_addr", {16'd0, m4_addr}, 32'h0012);
        end
        chk("b2b_stall_pattern", {18'd0, st_pat}, {18'd0, 14'b00011111011111});
        chk("b2b_mem_en_pattern", {18'd0, en_pat}, {18'd0, 14'b00011110011110});
        chk("b2b_valid_pattern", {18'd0, vl_pat}, {18'd0, 14'b00000000100000});
        chk("b2b_acc", {16'd0, acc4}, {16'd0, 16'(acc_before + 16'd2)});
        chk("b2b_mem_written", {16'd0, mem[8'h12]}, 32'h7777);

        // Reset pulsed on the second BUSY cycle of a read.
        @(posedge clk); #1;
        r4_en = 1'b1; r4_wr = 1'b0; r4_addr = 16'h0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; r4_en = 1'b0;
        @(negedge clk);
        chk("rstbusy_mem_en", {31'd0, m4_en}, 32'd0);
        chk("rstbusy_stall", {31'd0, stall4}, 32'd0);
        chk("rstbusy_valid", {31'd0, valid4}, 32'd0);
        chk("rstbusy_acc", {16'd0, acc4}, 32'd0);
        chk("rstbusy_rdata", {16'd0, rdata4}, 32'd0);
        bad_flag = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valid4 || m4_en) bad_flag = 1'b1;
        end
        chk("rstbusy_no_done", {31'd0, bad_flag}, 32'd0);

        // Reset together with req_en: the request must not be accepted.
        @(posedge clk); #1;
        rst = 1'b1; r4_en = 1'b1; r4_wr = 1'b0; r4_addr = 16'h0010;
        @(posedge clk); #1;
        rst = 1'b0; r4_en = 1'b0;
        @(negedge clk);
        chk("rstprio_mem_en", {31'd0, m4_en}, 32'd0);
        chk("rstprio_stall", {31'd0, stall4}, 32'd0);

        // LATENCY=1 instance: one BUSY cycle, data on cycle 2.
        @(posedge clk); #1;
        r1_en = 1'b1; r1_wr = 1'b0; r1_addr = 16'h0004;
        @(negedge clk);
        chk("lat1_c0_stall", {31'd0, stall1}, 32'd1);
        @(posedge clk); #1;
        r1_en = 1'b0; r1_addr = 16'h0000;
        @(negedge clk);
        chk("lat1_c1_stall", {31'd0, stall1}, 32'd1);
        chk("lat1_c1_mem_en", {31'd0, m1_en}, 32'd1);
        chk("lat1_c1_addr", {16'd0, m1_addr}, 32'h0004);
        @(negedge clk);
        chk("lat1_c2_stall", {31'd0, stall1}, 32'd0);
        chk("lat1_c2_valid", {31'd0, valid1}, 32'd1);
        chk("lat1_c2_rdata", {16'd0, rdata1}, 32'h00FF);
        chk("lat1_c2_acc", {16'd0, acc1}, 32'd1);

        // Access counter wrap from 0xFFFF.
        @(negedge clk);
        force dut4.acc_q = 16'hFFFF;
        @(negedge clk);
        release dut4.acc_q;
        chk("wrap_preload", {16'd0, acc4}, 32'hFFFF);
        access4(1'b0, 16'h0010, 16'h0000, busy, rd, vld);
        chk("wrap_acc", {16'd0, acc4}, 32'h0000);
        chk("wrap_rdata", {16'd0, rd}, 32'h1234);
        chk("wrap_valid", {31'd0, vld}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
